// File: rtl/core_pkg.sv
// Shared core types: hazard FSM states, pipeline control bundle, NOP.
// Imported by the pipeline control blocks.
package core_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        ERROR = 2'd2
    } state_t;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic ex_mem_hold;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam hz_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam hz_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2
    );
        return mem_read && (rd != 5'd0) && (rd == rs1 || rd == rs2);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller: load-use stalls, branch flushes,
// data-memory wait freeze with watchdog, and saturating perf counters.
module hazard_stall_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_memRead,
    input  logic             EX_branch_taken,
    input  logic             EX_MEM_memRead,
    input  logic             EX_MEM_memWrite,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             ID_EX_bubble,
    output logic             EX_MEM_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    import core_pkg::*;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    hz_ctrl_t   ctrl;
    logic       mem_acc;
    logic       mem_busy;
    logic       freeze;
    logic       lu;

    assign mem_acc  = EX_MEM_memRead | EX_MEM_memWrite;
    assign mem_busy = mem_acc & ~mem_ready;
    assign freeze   = mem_busy | (state == ERROR);
    assign lu       = load_use(ID_EX_memRead, ID_EX_rd,
                               IF_ID_rs1, IF_ID_rs2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        unique case (state)
            RUN: begin
                if (mem_busy) begin
                    if (TIMEOUT == 1) begin
                        state_nxt = ERROR;
                    end else begin
                        state_nxt    = WAIT;
                        wait_cnt_nxt = 8'd1;
                    end
                end
            end
            WAIT: begin
                if (mem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = 8'd0;
                end else if (wait_cnt == TMO_LAST) begin
                    state_nxt = ERROR;
                end else begin
                    wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = 8'd0;
            end
        endcase
    end

    // A frozen pipeline keeps the branch in EX, so its flush lands later.
    always_comb begin
        ctrl = CTRL_RUN;
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (EX_branch_taken) begin
            ctrl = CTRL_BRANCH;
        end else if (lu) begin
            ctrl = CTRL_LU;
        end
    end

    assign pc_write     = ctrl.pc_write;
    assign IF_ID_write  = ctrl.if_id_write;
    assign IF_ID_flush  = ctrl.if_id_flush;
    assign ID_EX_bubble = ctrl.id_ex_bubble;
    assign EX_MEM_hold  = ctrl.ex_mem_hold;
    assign mem_timeout  = (state == ERROR);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (~ctrl.pc_write),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.if_id_flush),
        .count (flush_count)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed testbench for hazard_stall_ctrl; a second small instance
// (TIMEOUT=1, CNT_W=2) exercises immediate error and saturation.
module tb_hazard_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rd;
    logic       ID_EX_memRead, EX_branch_taken;
    logic       EX_MEM_memRead, EX_MEM_memWrite, mem_ready;

    logic        pc_write, IF_ID_write, IF_ID_flush;
    logic        ID_EX_bubble, EX_MEM_hold, mem_timeout;
    logic [15:0] stall_cycles, flush_count;

    logic       b_pc_write, b_IF_ID_write, b_IF_ID_flush;
    logic       b_ID_EX_bubble, b_EX_MEM_hold, b_mem_timeout;
    logic [1:0] b_stall_cycles, b_flush_count;

    logic [4:0] ctrl, b_ctrl;

    int n_cmp = 0;
    int n_bad = 0;

    // {pc_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_MEM_hold}
    localparam logic [4:0] C_RUN = 5'b11000;
    localparam logic [4:0] C_LU  = 5'b00010;
    localparam logic [4:0] C_BR  = 5'b11110;
    localparam logic [4:0] C_FRZ = 5'b00001;
    localparam logic [4:0] C_RST = 5'b00110;

    always #5 clk = ~clk;

    assign ctrl = {pc_write, IF_ID_write, IF_ID_flush,
                   ID_EX_bubble, EX_MEM_hold};
    assign b_ctrl = {b_pc_write, b_IF_ID_write, b_IF_ID_flush,
                     b_ID_EX_bubble, b_EX_MEM_hold};

    hazard_stall_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2),
        .ID_EX_rd        (ID_EX_rd),
        .ID_EX_memRead   (ID_EX_memRead),
        .EX_branch_taken (EX_branch_taken),
        .EX_MEM_memRead  (EX_MEM_memRead),
        .EX_MEM_memWrite (EX_MEM_memWrite),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .IF_ID_write     (IF_ID_write),
        .IF_ID_flush     (IF_ID_flush),
        .ID_EX_bubble    (ID_EX_bubble),
        .EX_MEM_hold     (EX_MEM_hold),
        .mem_timeout     (mem_timeout),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
    );

    hazard_stall_ctrl #(.TIMEOUT(1), .CNT_W(2)) dut_s (
        .clk             (clk),
        .rst_n           (rst_n),
        .IF_ID_rs1       (IF_ID_rs1),
        .IF_ID_rs2       (IF_ID_rs2),
        .ID_EX_rd        (ID_EX_rd),
        .ID_EX_memRead   (ID_EX_memRead),
        .EX_branch_taken (EX_branch_taken),
        .EX_MEM_memRead  (EX_MEM_memRead),
        .EX_MEM_memWrite (EX_MEM_memWrite),
        .mem_ready       (mem_ready),
        .pc_write        (b_pc_write),
        .IF_ID_write     (b_IF_ID_write),
        .IF_ID_flush     (b_IF_ID_flush),
        .ID_EX_bubble    (b_ID_EX_bubble),
        .EX_MEM_hold     (b_EX_MEM_hold),
        .mem_timeout     (b_mem_timeout),
        .stall_cycles    (b_stall_cycles),
        .flush_count     (b_flush_count)
    );

    task automatic idle();
        IF_ID_rs1       = 5'd0;
        IF_ID_rs2       = 5'd0;
        ID_EX_rd        = 5'd0;
        ID_EX_memRead   = 1'b0;
        EX_branch_taken = 1'b0;
        EX_MEM_memRead  = 1'b0;
        EX_MEM_memWrite = 1'b0;
        mem_ready       = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        #2;
        n_cmp++;
        if (ctrl !== C_RST) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want %b", ctrl, C_RST);
        end
        n_cmp++;
        if (mem_timeout !== 1'b0 || stall_cycles !== 16'd0 ||
            flush_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_state: tmo %b stall %0d flush %0d want 0/0/0",
                     mem_timeout, stall_cycles, flush_count);
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_RUN) begin
            n_bad++;
            $display("FAIL reset_release: got %b want %b", ctrl, C_RUN);
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_cnt: stall %0d flush %0d want 0/0",
                     stall_cycles, flush_count);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        ID_EX_memRead = 1'b1;
        ID_EX_rd      = 5'd5;
        IF_ID_rs1     = 5'd3;
        IF_ID_rs2     = 5'd5;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_LU) begin
            n_bad++;
            $display("FAIL lu_stall: got %b want %b", ctrl, C_LU);
        end
        tick();
        ID_EX_memRead  = 1'b0;
        ID_EX_rd       = 5'd0;
        EX_MEM_memRead = 1'b1;
        mem_ready      = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_RUN) begin
            n_bad++;
            $display("FAIL lu_next: got %b want %b", ctrl, C_RUN);
        end
        n_cmp++;
        if (stall_cycles !== 16'd1) begin
            n_bad++;
            $display("FAIL lu_stall_cnt: got %0d want 1", stall_cycles);
        end
    endtask

    task automatic test_lu_vectors();
        logic [15:0] vec [5];
        logic [4:0]  exp [5];
        // {memRead, rd, rs1, rs2}
        vec[0] = {1'b1, 5'd5, 5'd3, 5'd5}; exp[0] = C_LU;
        vec[1] = {1'b1, 5'd7, 5'd7, 5'd0}; exp[1] = C_LU;
        vec[2] = {1'b1, 5'd7, 5'd6, 5'd8}; exp[2] = C_RUN;
        vec[3] = {1'b0, 5'd5, 5'd5, 5'd5}; exp[3] = C_RUN;
        vec[4] = {1'b1, 5'd0, 5'd0, 5'd0}; exp[4] = C_RUN;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            {ID_EX_memRead, ID_EX_rd, IF_ID_rs1, IF_ID_rs2} = vec[i];
            @(negedge clk);
            n_cmp++;
            if (ctrl !== exp[i]) begin
                n_bad++;
                $display("FAIL lu_vec%0d: got %b want %b", i, ctrl, exp[i]);
            end
            tick();
        end
    endtask

    task automatic test_x0_load();
        do_reset();
        ID_EX_memRead = 1'b1;
        ID_EX_rd      = 5'd0;
        IF_ID_rs1     = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (pc_write !== 1'b1) begin
            n_bad++;
            $display("FAIL x0_pc_write: got %b want 1", pc_write);
        end
        tick();
        n_cmp++;
        if (stall_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL x0_stall_cnt: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_branch_lu();
        do_reset();
        EX_branch_taken = 1'b1;
        ID_EX_memRead   = 1'b1;
        ID_EX_rd        = 5'd5;
        IF_ID_rs2       = 5'd5;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_BR) begin
            n_bad++;
            $display("FAIL br_lu_ctrl: got %b want %b", ctrl, C_BR);
        end
        tick();
        idle();
        @(negedge clk);
        n_cmp++;
        if (flush_count !== 16'd1 || stall_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL br_lu_cnt: flush %0d stall %0d want 1/0",
                     flush_count, stall_cycles);
        end
        n_cmp++;
        if (ctrl !== C_RUN) begin
            n_bad++;
            $display("FAIL br_lu_after: got %b want %b", ctrl, C_RUN);
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        EX_MEM_memRead = 1'b1;
        mem_ready      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl !== C_FRZ) begin
                n_bad++;
                $display("FAIL wait_frz%0d: got %b want %b", i, ctrl, C_FRZ);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_RUN) begin
            n_bad++;
            $display("FAIL wait_done: got %b want %b", ctrl, C_RUN);
        end
        tick();
        idle();
        n_cmp++;
        if (stall_cycles !== 16'd3 || mem_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_cnt: stall %0d tmo %b want 3/0",
                     stall_cycles, mem_timeout);
        end
        EX_MEM_memWrite = 1'b1;
        mem_ready       = 1'b0;
        repeat (3) tick();
        mem_ready = 1'b1;
        tick();
        idle();
        n_cmp++;
        if (stall_cycles !== 16'd6 || mem_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL wait_again: stall %0d tmo %b want 6/0",
                     stall_cycles, mem_timeout);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        EX_MEM_memRead = 1'b1;
        mem_ready      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl !== C_FRZ || mem_timeout !== 1'b0) begin
                n_bad++;
                $display("FAIL tmo_wait%0d: ctrl %b tmo %b want %b/0",
                         i, ctrl, mem_timeout, C_FRZ);
            end
            tick();
        end
        n_cmp++;
        if (mem_timeout !== 1'b1 || stall_cycles !== 16'd4) begin
            n_bad++;
            $display("FAIL tmo_set: tmo %b stall %0d want 1/4",
                     mem_timeout, stall_cycles);
        end
        mem_ready       = 1'b1;
        EX_branch_taken = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_FRZ) begin
            n_bad++;
            $display("FAIL tmo_frozen: got %b want %b", ctrl, C_FRZ);
        end
        tick();
        n_cmp++;
        if (mem_timeout !== 1'b1 || stall_cycles !== 16'd5) begin
            n_bad++;
            $display("FAIL tmo_sticky: tmo %b stall %0d want 1/5",
                     mem_timeout, stall_cycles);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ctrl !== C_RST || mem_timeout !== 1'b0 ||
            stall_cycles !== 16'd0 || flush_count !== 16'd0) begin
            n_bad++;
            $display("FAIL tmo_reset: ctrl %b tmo %b stall %0d flush %0d",
                     ctrl, mem_timeout, stall_cycles, flush_count);
        end
        tick();
        rst_n = 1'b1;
        idle();
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_RUN) begin
            n_bad++;
            $display("FAIL tmo_release: got %b want %b", ctrl, C_RUN);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        EX_MEM_memRead = 1'b1;
        mem_ready      = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (ctrl !== C_RST || stall_cycles !== 16'd0) begin
            n_bad++;
            $display("FAIL midwait_reset: ctrl %b stall %0d want %b/0",
                     ctrl, stall_cycles, C_RST);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ctrl !== C_FRZ) begin
                n_bad++;
                $display("FAIL midwait_frz%0d: got %b want %b", i, ctrl, C_FRZ);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_RUN || mem_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL midwait_ready: ctrl %b tmo %b want %b/0",
                     ctrl, mem_timeout, C_RUN);
        end
        tick();
        idle();
        n_cmp++;
        if (stall_cycles !== 16'd3 || mem_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL midwait_cnt: stall %0d tmo %b want 3/0",
                     stall_cycles, mem_timeout);
        end
    endtask

    task automatic test_freeze_branch();
        do_reset();
        EX_MEM_memRead  = 1'b1;
        mem_ready       = 1'b0;
        EX_branch_taken = 1'b1;
        ID_EX_memRead   = 1'b1;
        ID_EX_rd        = 5'd5;
        IF_ID_rs1       = 5'd5;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_FRZ) begin
            n_bad++;
            $display("FAIL frz_br_first: got %b want %b", ctrl, C_FRZ);
        end
        tick();
        mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctrl !== C_BR) begin
            n_bad++;
            $display("FAIL frz_br_flush: got %b want %b", ctrl, C_BR);
        end
        tick();
        idle();
        n_cmp++;
        if (flush_count !== 16'd1 || stall_cycles !== 16'd1) begin
            n_bad++;
            $display("FAIL frz_br_cnt: flush %0d stall %0d want 1/1",
                     flush_count, stall_cycles);
        end
    endtask

    task automatic test_sat_error();
        do_reset();
        EX_MEM_memRead = 1'b1;
        mem_ready      = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_ctrl !== C_FRZ || b_mem_timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL t1_first: ctrl %b tmo %b want %b/0",
                     b_ctrl, b_mem_timeout, C_FRZ);
        end
        tick();
        n_cmp++;
        if (b_mem_timeout !== 1'b1 || b_stall_cycles !== 2'd1) begin
            n_bad++;
            $display("FAIL t1_error: tmo %b stall %0d want 1/1",
                     b_mem_timeout, b_stall_cycles);
        end
        mem_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (b_ctrl !== C_FRZ) begin
            n_bad++;
            $display("FAIL t1_frozen: got %b want %b", b_ctrl, C_FRZ);
        end
        repeat (4) tick();
        n_cmp++;
        if (b_stall_cycles !== 2'd3 || b_flush_count !== 2'd0) begin
            n_bad++;
            $display("FAIL stall_sat: stall %0d flush %0d want 3/0",
                     b_stall_cycles, b_flush_count);
        end
    endtask

    task automatic test_flush_sat();
        do_reset();
        EX_branch_taken = 1'b1;
        repeat (5) tick();
        idle();
        n_cmp++;
        if (b_flush_count !== 2'd3 || b_stall_cycles !== 2'd0) begin
            n_bad++;
            $display("FAIL flush_sat: flush %0d stall %0d want 3/0",
                     b_flush_count, b_stall_cycles);
        end
        n_cmp++;
        if (flush_count !== 16'd5) begin
            n_bad++;
            $display("FAIL flush_cnt: got %0d want 5", flush_count);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_lu_vectors();
        test_x0_load();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_freeze_branch();
        test_sat_error();
        test_flush_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline hazard and stall controller for the 5-stage RISC-V core. It generates the stall, bubble, flush and hold controls that the forwarding logic cannot resolve: load-use hazards, taken-branch flushes, and multi-cycle data-memory waits. It also implements a watchdog on data-memory waits and saturating performance counters. It sits beside the forwarding unit and drives the PC, IF/ID, ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- TIMEOUT, 255: consecutive not-ready memory cycles before a timeout error; range 1..255.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- IF_ID_rs1  in  5  rs1 of the instruction in ID.
- IF_ID_rs2  in  5  rs2 of the instruction in ID.
- ID_EX_rd  in  5  rd of the instruction in EX.
- ID_EX_memRead  in  1  instruction in EX is a load.
- EX_branch_taken  in  1  branch or jump in EX resolved as taken.
- EX_MEM_memRead  in  1  load in MEM.
- EX_MEM_memWrite  in  1  store in MEM.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC may update.
- IF_ID_write  out  1  IF/ID may load.
- IF_ID_flush  out  1  IF/ID loads a NOP.
- ID_EX_bubble  out  1  ID/EX loads a NOP (control bits zeroed).
- EX_MEM_hold  out  1  EX/MEM and MEM/WB keep their contents.
- mem_timeout  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.
- flush_count  out  CNT_W  saturating count of cycles with IF_ID_flush=1.

## Operation
Terms:
- mem_acc = EX_MEM_memRead | EX_MEM_memWrite.
- freeze = (mem_acc & ~mem_ready) | state==ERROR.
- lu = ID_EX_memRead & ID_EX_rd!=0 & (ID_EX_rd==IF_ID_rs1 | ID_EX_rd==IF_ID_rs2).

Output priority, evaluated combinationally each cycle (highest first):
1. freeze: pc_write=0, IF_ID_write=0, IF_ID_flush=0, ID_EX_bubble=0, EX_MEM_hold=1. The whole pipeline holds, and a pending branch in EX stays in EX.
2. EX_branch_taken: pc_write=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_bubble=1, EX_MEM_hold=0. This also overrides lu, because the instruction in ID is wrong-path.
3. lu: pc_write=0, IF_ID_write=0, ID_EX_bubble=1, flush=0, hold=0.
4. Otherwise: pc_write=1, IF_ID_write=1, all other controls 0.

FSM (state register plus wait_cnt, 8 bits):
- RUN:
  - mem_acc & ~mem_ready: go to WAIT, wait_cnt=1. If TIMEOUT==1, go to ERROR instead.
  - Otherwise: stay in RUN.
- WAIT:
  - mem_ready: go to RUN, wait_cnt=0.
  - ~mem_ready & wait_cnt==TIMEOUT-1: go to ERROR.
  - Otherwise: wait_cnt+1.
- ERROR:
  - mem_timeout=1, freeze permanently.
  - Left only by reset.

Counters:
- stall_cycles increments on every cycle with pc_write=0.
- flush_count increments on every cycle with IF_ID_flush=1.
- Both saturate at 2^CNT_W-1 and never wrap.

## Timing
- Control outputs are combinational from inputs and state, with zero-cycle latency.
- State, wait_cnt, mem_timeout and the counters are registered.
- While rst_n=0: pc_write=0, IF_ID_write=0, IF_ID_flush=1, ID_EX_bubble=1, EX_MEM_hold=0, mem_timeout=0, counters 0, state RUN, wait_cnt 0.
- The first normal control values appear in the cycle after rst_n deasserts.
- Load-use costs exactly one stall cycle. Next cycle the load has moved to MEM and lu clears by construction.
- mem_ready high in the first MEM cycle: no stall.
- An access ready after N not-ready cycles costs N freeze cycles.
- Exactly TIMEOUT consecutive not-ready cycles enter ERROR on the following edge.
- Reset asserted mid-WAIT or in ERROR clears all state immediately (asynchronous).
- Simultaneous freeze, branch and lu: freeze wins. The flush is applied in the first non-freeze cycle, while the branch is still in EX.

## Structure
- Shared package core_pkg:
  - FSM state localparams: RUN=2'd0, WAIT=2'd1, ERROR=2'd2.
  - The NOP encoding used by the bubble and flush paths.
- One sub-module, sat_counter (parameter W; inputs clk, rst_n, inc; output count), instanced twice.
- All priority logic lives in a single combinational block in this module.

## Test plan
- Load-use: ID_EX_memRead=1, ID_EX_rd=5, IF_ID_rs2=5 -> one cycle with pc_write=0, IF_ID_write=0, ID_EX_bubble=1; normal next cycle; stall_cycles=1.
- x0 load: ID_EX_rd=0, IF_ID_rs1=0, ID_EX_memRead=1 -> no stall, pc_write=1.
- Branch plus load-use same cycle: EX_branch_taken=1 with lu true -> IF_ID_flush=1, ID_EX_bubble=1, pc_write=1; flush_count=1, stall_cycles=0.
- Memory wait: EX_MEM_memRead=1, mem_ready low 3 cycles then high -> EX_MEM_hold=1 for exactly 3 cycles; state returns to RUN; stall_cycles=3.
- Timeout: TIMEOUT=4, mem_ready held low -> mem_timeout=1 after 4 freeze cycles; pipeline stays frozen; rst_n pulse clears everything to reset values.
- Reset mid-wait: rst_n low during cycle 2 of WAIT -> outputs take reset values immediately; after release, mem_ready=1 gives no freeze.
